// File: rtl/int8_mac_pkg.sv
// Shared constants and types for the int8 MAC datapath and its dot-product sequencer.
package int8_mac_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int8_mac_pp_feedback.sv
// Combinational signed int8 multiply-accumulate: result = a*b + acc, modulo 2^16.
module int8_mac_pp_feedback
  import int8_mac_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  result
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] pp_sum;

  assign a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};

  // Partial products of the sign-extended multiplicand; the multiplier MSB
  // carries negative weight, so its row is subtracted.
  always_comb begin
    pp_sum = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (b[i]) begin
        if (i == DATA_W - 1) pp_sum = pp_sum - (a_ext << i);
        else                 pp_sum = pp_sum + (a_ext << i);
      end
    end
    result = pp_sum + acc;
  end

endmodule

// File: rtl/int8_mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs through one int8 MAC, feeding
// the running sum back as the accumulator, and hands the result downstream.
module int8_mac_dot_seq #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = int8_mac_pkg::DATA_W,
  parameter int unsigned ACC_W  = int8_mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ACC_W-1:0]  acc_init,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  import int8_mac_pkg::*;

  state_t           state;
  acc_t             acc;
  logic [ACC_W-1:0] mac_res;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] last_idx;

  int8_mac_pp_feedback u_mac (
    .a      (in_a),
    .b      (in_b),
    .acc    (acc),
    .result (mac_res)
  );

  assign last_idx = len_q - 1'b1;

  // abort has priority over every other transition, including handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
    end else if (abort) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= acc_init;
            len_q <= len;
            count <= '0;
            state <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            acc   <= mac_res;
            count <= count + 1'b1;
            if (count == last_idx) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_data  = (state == DONE) ? acc : '0;
  assign busy      = (state != IDLE);

endmodule
